// File: rtl/spi_reg_bank_pkg.sv
// Shared constants for SPI-side peripherals: command byte layout,
// register-window size and the peripheral IDs handed out across the system.
package spi_reg_bank_pkg;

  localparam int CMD_WR_BIT     = 7;
  localparam int CMD_PERIPH_MSB = 6;
  localparam int CMD_PERIPH_LSB = 3;
  localparam int CMD_ADDR_MSB   = 2;
  localparam int CMD_ADDR_LSB   = 0;

  localparam int REG_COUNT = 8;

  localparam logic [3:0] PERIPH_ID_CTRL = 4'd1;
  localparam logic [3:0] PERIPH_ID_AUX  = 4'd2;

  // Register targeted by the current byte; the 3-bit sum wraps 7 -> 0.
  function automatic logic [2:0] reg_addr(input logic [7:0] cmd, input logic [2:0] off);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB] + off;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Byte-level handshake between the SPI slave shifter and an SPI-side peripheral.
interface spi_reg_bank_if;

  logic       iSPI_SS_n;
  logic       iSPI_IN;
  logic [7:0] iSPI_RCV_CMD;
  logic [7:0] iSPI_RCV_BYTE;
  logic [4:0] iSPI_PERIPH_SLCT;
  logic [7:0] oSPI_SEND_BYTE;

  modport master (
    output iSPI_SS_n, iSPI_IN, iSPI_RCV_CMD, iSPI_RCV_BYTE, iSPI_PERIPH_SLCT,
    input  oSPI_SEND_BYTE
  );

  modport slave (
    input  iSPI_SS_n, iSPI_IN, iSPI_RCV_CMD, iSPI_RCV_BYTE, iSPI_PERIPH_SLCT,
    output oSPI_SEND_BYTE
  );

endinterface

// File: rtl/spi_byte_tracker.sv
// Bit/byte/register-offset position within an SPI transaction, cleared whenever
// chip select is released; reusable by any peripheral sitting on SCK.
module spi_byte_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  output logic [2:0] bit_cnt,
  output logic [1:0] byte_cnt,
  output logic [2:0] off,
  output logic       locked
);

  // byte_cnt saturates at 2: only "command byte" vs "data phase" matters.
  always_ff @(posedge clk or posedge rst or posedge ss_n) begin
    if (rst || ss_n) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      off      <= '0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        if (byte_cnt != 2'd2) byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt != 2'd0) off <= off + 3'd1;
      end
    end
  end

  // A reset landing inside a transaction leaves byte alignment unknown, so the
  // transaction stays locked until chip select is released.
  always_ff @(posedge rst or posedge ss_n) begin
    if (ss_n) locked <= 1'b0;
    else      locked <= 1'b1;
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Eight-byte register window on the SCK domain: burst writes into the control
// registers, burst reads of control and status bytes back out on MISO.
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter logic [3:0] PERIPH_ID = PERIPH_ID_CTRL,
  parameter int         NUM_RW    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  spi_reg_bank_if.slave                 spi,
  input  logic [(REG_COUNT-NUM_RW)*8-1:0] iSTATUS,
  output logic [NUM_RW*8-1:0]           oCTRL,
  output logic [NUM_RW-1:0]             oCTRL_TGL
);

  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [2:0] off;
  logic       locked;

  spi_byte_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (spi.iSPI_SS_n),
    .bit_cnt  (bit_cnt),
    .byte_cnt (byte_cnt),
    .off      (off),
    .locked   (locked)
  );

  logic [2:0] addr;
  logic       sel;
  logic       is_write;
  logic       data_phase;
  logic       addr_rw;
  logic       wr_accept;
  logic [7:0] rd_byte;
  logic [7:0] send_q;
  logic       unused_bits;

  assign addr       = reg_addr(spi.iSPI_RCV_CMD, off);
  assign sel        = (spi.iSPI_PERIPH_SLCT[3:0] == PERIPH_ID);
  assign is_write   = spi.iSPI_RCV_CMD[CMD_WR_BIT];
  assign data_phase = (byte_cnt != 2'd0);
  assign addr_rw    = ({1'b0, addr} < 4'(NUM_RW));
  assign wr_accept  = (bit_cnt == 3'd7) && data_phase && is_write && sel && addr_rw && !locked;

  assign unused_bits = ^{spi.iSPI_IN, spi.iSPI_PERIPH_SLCT[4],
                         spi.iSPI_RCV_CMD[CMD_PERIPH_MSB:CMD_PERIPH_LSB]};

  // The received byte is only complete at the 8th SCK edge, so it is captured there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oCTRL     <= '0;
      oCTRL_TGL <= '0;
    end else if (wr_accept) begin
      for (int r = 0; r < NUM_RW; r++) begin
        if (addr == 3'(r)) begin
          oCTRL[r*8 +: 8] <= spi.iSPI_RCV_BYTE;
          oCTRL_TGL[r]    <= ~oCTRL_TGL[r];
        end
      end
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    for (int r = 0; r < NUM_RW; r++) begin
      if (addr == 3'(r)) rd_byte = oCTRL[r*8 +: 8];
    end
    for (int s = 0; s < REG_COUNT - NUM_RW; s++) begin
      if (addr == 3'(NUM_RW + s)) rd_byte = iSTATUS[s*8 +: 8];
    end
  end

  // Loaded on the falling edge right after a byte boundary (bit_cnt has just
  // wrapped to 0), giving the shifter half a cycle of setup before bit 7.
  always_ff @(negedge clk or posedge rst or posedge spi.iSPI_SS_n) begin
    if (rst || spi.iSPI_SS_n) begin
      send_q <= 8'h00;
    end else if (bit_cnt == 3'd0 && data_phase) begin
      send_q <= (sel && !is_write) ? rd_byte : 8'h00;
    end
  end

  assign spi.oSPI_SEND_BYTE = send_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: table of burst transactions plus hand-written
// abort and mid-transaction reset sequences.
module tb_spi_reg_bank;
  import spi_reg_bank_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] status;
  logic [31:0] ctrl;
  logic [3:0]  ctrl_tgl;

  int checks;
  int errors;

  spi_reg_bank_if bus();

  spi_reg_bank #(
    .PERIPH_ID (PERIPH_ID_CTRL),
    .NUM_RW    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (bus.slave),
    .iSTATUS   (status),
    .oCTRL     (ctrl),
    .oCTRL_TGL (ctrl_tgl)
  );

  // Behavioural stand-in for the SPI slave shifter feeding the bank.
  logic [2:0] m_bit;
  logic [6:0] m_sh;
  logic       m_have_cmd;
  logic [7:0] m_cmd;

  always @(posedge clk or posedge bus.iSPI_SS_n) begin
    if (bus.iSPI_SS_n) begin
      m_bit      <= '0;
      m_sh       <= '0;
      m_have_cmd <= 1'b0;
      m_cmd      <= '0;
    end else begin
      m_bit <= m_bit + 3'd1;
      m_sh  <= {m_sh[5:0], bus.iSPI_IN};
      if (m_bit == 3'd7 && !m_have_cmd) begin
        m_cmd      <= {m_sh, bus.iSPI_IN};
        m_have_cmd <= 1'b1;
      end
    end
  end

  assign bus.iSPI_RCV_BYTE    = {m_sh, bus.iSPI_IN};
  assign bus.iSPI_RCV_CMD     = m_cmd;
  assign bus.iSPI_PERIPH_SLCT = {1'b0, m_cmd[CMD_PERIPH_MSB:CMD_PERIPH_LSB]};

  // data: byte 1 in [7:0]; exp_miso: byte shifted out during cmd byte in [7:0].
  typedef struct packed {
    logic [7:0]  cmd;
    logic [2:0]  n;
    logic [31:0] data;
    logic [31:0] exp_ctrl;
    logic [3:0]  exp_tgl;
    logic [39:0] exp_miso;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sckBit(input logic b);
    bus.iSPI_IN = b;
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, output logic [7:0] miso);
    #1 miso = bus.oSPI_SEND_BYTE;
    for (int i = 7; i >= 0; i--) sckBit(b[i]);
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [2:0] n,
                               input logic [31:0] data, output logic [39:0] miso);
    logic [7:0] m;
    miso = '0;
    bus.iSPI_SS_n = 1'b0;
    #5;
    sendByte(cmd, m);
    miso[7:0] = m;
    for (int k = 0; k < int'(n); k++) begin
      sendByte(data[k*8 +: 8], m);
      miso[(k+1)*8 +: 8] = m;
    end
    #5 bus.iSPI_SS_n = 1'b1;
    #5;
  endtask

  initial begin
    logic [39:0] miso;
    logic [7:0]  m;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b0;
    bus.iSPI_SS_n = 1'b0;
    bus.iSPI_IN   = 1'b0;
    status = 32'hDDCCBBAA;

    vecs[0] = '{cmd:8'h88, n:3'd3, data:32'h00332211, exp_ctrl:32'h00332211, exp_tgl:4'b0111, exp_miso:40'h0};
    vecs[1] = '{cmd:8'h8B, n:3'd1, data:32'h00000044, exp_ctrl:32'h44332211, exp_tgl:4'b1111, exp_miso:40'h0};
    vecs[2] = '{cmd:8'h0E, n:3'd4, data:32'h00000000, exp_ctrl:32'h44332211, exp_tgl:4'b1111, exp_miso:40'h2211DDCC00};
    vecs[3] = '{cmd:8'h8C, n:3'd1, data:32'h00000055, exp_ctrl:32'h44332211, exp_tgl:4'b1111, exp_miso:40'h0};
    vecs[4] = '{cmd:8'h90, n:3'd1, data:32'h00000066, exp_ctrl:32'h44332211, exp_tgl:4'b1111, exp_miso:40'h0};
    vecs[5] = '{cmd:8'h10, n:3'd2, data:32'h00000000, exp_ctrl:32'h44332211, exp_tgl:4'b1111, exp_miso:40'h0};
    vecs[6] = '{cmd:8'h0A, n:3'd2, data:32'h00000000, exp_ctrl:32'h44332211, exp_tgl:4'b1111, exp_miso:40'h0000443300};
    vecs[7] = '{cmd:8'h8F, n:3'd2, data:32'h00009977, exp_ctrl:32'h44332299, exp_tgl:4'b1110, exp_miso:40'h0};
    vecs[8] = '{cmd:8'h0F, n:3'd3, data:32'h00000000, exp_ctrl:32'h44332299, exp_tgl:4'b1110, exp_miso:40'h002299DD00};

    #1 bus.iSPI_SS_n = 1'b1;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #5;
    checkOutput("reset_ctrl", 40'(ctrl), 40'h0);
    checkOutput("reset_tgl",  40'(ctrl_tgl), 40'h0);
    checkOutput("reset_send", 40'(bus.oSPI_SEND_BYTE), 40'h0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].n, vecs[i].data, miso);
      checkOutput($sformatf("vec%0d_ctrl", i), 40'(ctrl), 40'(vecs[i].exp_ctrl));
      checkOutput($sformatf("vec%0d_tgl", i),  40'(ctrl_tgl), 40'(vecs[i].exp_tgl));
      for (int k = 0; k <= int'(vecs[i].n); k++)
        checkOutput($sformatf("vec%0d_miso%0d", i, k), 40'(miso[k*8 +: 8]), 40'(vecs[i].exp_miso[k*8 +: 8]));
    end

    // Read aborted mid-byte: loaded byte must drop back to zero with SS_n.
    bus.iSPI_SS_n = 1'b0;
    #5;
    sendByte(8'h08, m);
    for (int i = 0; i < 3; i++) sckBit(1'b0);
    #1 checkOutput("abort_rd_loaded", 40'(bus.oSPI_SEND_BYTE), 40'h99);
    bus.iSPI_SS_n = 1'b1;
    #2 checkOutput("abort_rd_clear", 40'(bus.oSPI_SEND_BYTE), 40'h0);
    #5;

    // Write aborted after 5 bits, then a clean write to the same register.
    bus.iSPI_SS_n = 1'b0;
    #5;
    sendByte(8'h89, m);
    for (int i = 0; i < 5; i++) sckBit(1'b1);
    #5 bus.iSPI_SS_n = 1'b1;
    #5;
    checkOutput("abort_wr_ctrl", 40'(ctrl), 40'h44332299);
    checkOutput("abort_wr_tgl",  40'(ctrl_tgl), 40'hE);
    applyStimulus(8'h89, 3'd1, 32'h0000007E, miso);
    checkOutput("after_abort_ctrl", 40'(ctrl), 40'h44337E99);
    checkOutput("after_abort_tgl",  40'(ctrl_tgl), 40'hC);

    // Reset during the second data byte of a write burst.
    bus.iSPI_SS_n = 1'b0;
    #5;
    sendByte(8'h88, m);
    sendByte(8'hAB, m);
    #1 checkOutput("pre_rst_ctrl", 40'(ctrl), 40'h44337EAB);
    checkOutput("pre_rst_tgl", 40'(ctrl_tgl), 40'hD);
    for (int i = 0; i < 3; i++) sckBit(1'b1);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_ctrl", 40'(ctrl), 40'h0);
    checkOutput("mid_rst_tgl",  40'(ctrl_tgl), 40'h0);
    checkOutput("mid_rst_send", 40'(bus.oSPI_SEND_BYTE), 40'h0);
    for (int i = 0; i < 16; i++) sckBit(1'b1);
    #1 checkOutput("locked_ctrl", 40'(ctrl), 40'h0);
    checkOutput("locked_tgl", 40'(ctrl_tgl), 40'h0);
    #5 bus.iSPI_SS_n = 1'b1;
    #5;
    applyStimulus(8'h88, 3'd1, 32'h0000005A, miso);
    checkOutput("post_rst_ctrl", 40'(ctrl), 40'h5A);
    checkOutput("post_rst_tgl",  40'(ctrl_tgl), 40'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
